scan_lbist_ctrl: RTL and testbench

// On-chip logic-BIST controller for the scan-inserted system. Runs in the scan-clock domain in place of an external tester.
// An LFSR drives the scan-in of NUM_CHAINS chains, and the controller sequences the shift and capture windows (o_se, o_test_mode).
// The scan-outs are compacted into a MISR, and the final signature is compared against a golden value to give pass/fail.

---
 rtl/scan_lbist_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_scan_lbist_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_lbist_ctrl.sv
// -----------------------------------------------------------------------------
// scan_lbist_ctrl
// Logic-BIST controller. A Galois PRPG feeds the scan-in of NUM_CHAINS chains,
// the FSM sequences shift/capture windows, the scan-outs are compacted into a
// Galois MISR and the final signature is compared against a golden value.
//
// Ports
//   i_CLK           scan/test clock
//   i_RST           asynchronous reset, active-low
//   i_start         single-cycle start request (honoured in IDLE only)
//   i_abort         abort request, beats every other activity outside IDLE
//   i_num_patterns  number of patterns (capture events) to apply
//   i_golden_sig    expected signature, sampled in COMPARE
//   i_so            scan-out of each chain
//   o_si            scan-in of each chain (PRPG low bits during SHIFT, else 0)
//   o_se            scan enable (SHIFT and UNLOAD)
//   o_test_mode     high from INIT through COMPARE
//   o_busy          high in every state except IDLE
//   o_done          sticky completion flag
//   o_pass          signature match, valid while o_done=1
//   o_signature     current MISR contents
// -----------------------------------------------------------------------------
module scan_lbist_ctrl #(
    parameter int                    NUM_CHAINS     = 4,
    parameter int                    CHAIN_LEN      = 32,
    parameter int                    CAPTURE_CYCLES = 1,
    parameter int                    PAT_CNT_WIDTH  = 16,
    parameter int                    LFSR_WIDTH     = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY      = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = 16'hACE1,
    parameter int                    MISR_WIDTH     = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY      = 16'hB400,
    parameter logic [MISR_WIDTH-1:0] MISR_SEED      = 16'h0000
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [PAT_CNT_WIDTH-1:0] i_num_patterns,
    input  logic [MISR_WIDTH-1:0]    i_golden_sig,
    input  logic [NUM_CHAINS-1:0]    i_so,
    output logic [NUM_CHAINS-1:0]    o_si,
    output logic                     o_se,
    output logic                     o_test_mode,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [MISR_WIDTH-1:0]    o_signature
);

    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam int CW = $clog2(CAPTURE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE
    } state_t;

    state_t                   r_state;
    logic [LFSR_WIDTH-1:0]    r_lfsr;
    logic [MISR_WIDTH-1:0]    r_misr;
    logic [PAT_CNT_WIDTH-1:0] r_pat_cnt;
    logic [SW-1:0]            r_shift_cnt;
    logic [CW-1:0]            r_cap_cnt;
    logic                     r_first_load;
    logic [NUM_CHAINS-1:0]    r_si;
    logic                     r_se;
    logic                     r_test_mode;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;

    logic [LFSR_WIDTH-1:0]    w_lfsr_step;
    logic [MISR_WIDTH-1:0]    w_misr_step;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
        return {v[LFSR_WIDTH-2:0], 1'b0} ^ (v[LFSR_WIDTH-1] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [MISR_WIDTH-1:0] misr_step(input logic [MISR_WIDTH-1:0] v,
                                                        input logic [NUM_CHAINS-1:0] so);
        return {v[MISR_WIDTH-2:0], 1'b0} ^ (v[MISR_WIDTH-1] ? MISR_POLY : '0)
               ^ MISR_WIDTH'(so);
    endfunction

    assign w_lfsr_step = lfsr_step(r_lfsr);
    assign w_misr_step = misr_step(r_misr, i_so);

    // Outputs are registered: every transition sets the output values that
    // belong to the state being entered, so o_si always shows the PRPG value
    // that is live during the current SHIFT cycle.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_misr       <= MISR_SEED;
            r_pat_cnt    <= '0;
            r_shift_cnt  <= '0;
            r_cap_cnt    <= '0;
            r_first_load <= 1'b0;
            r_si         <= '0;
            r_se         <= 1'b0;
            r_test_mode  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            // Abandon the run; the MISR keeps its partial signature.
            r_state     <= S_IDLE;
            r_si        <= '0;
            r_se        <= 1'b0;
            r_test_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_INIT;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_test_mode <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                S_INIT: begin
                    r_lfsr    <= LFSR_SEED;
                    r_misr    <= MISR_SEED;
                    r_pat_cnt <= i_num_patterns;
                    if (i_num_patterns == '0) begin
                        r_state <= S_COMPARE;
                    end else begin
                        r_state      <= S_SHIFT;
                        r_first_load <= 1'b1;
                        r_shift_cnt  <= '0;
                        r_se         <= 1'b1;
                        r_si         <= LFSR_SEED[NUM_CHAINS-1:0];
                    end
                end

                S_SHIFT: begin
                    r_lfsr <= w_lfsr_step;
                    // The first load pushes out unknown power-up contents,
                    // which must not pollute the signature.
                    if (!r_first_load) begin
                        r_misr <= w_misr_step;
                    end
                    if (r_shift_cnt == SW'(CHAIN_LEN - 1)) begin
                        r_state      <= S_CAPTURE;
                        r_first_load <= 1'b0;
                        r_cap_cnt    <= '0;
                        r_se         <= 1'b0;
                        r_si         <= '0;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + SW'(1);
                        r_si        <= w_lfsr_step[NUM_CHAINS-1:0];
                    end
                end

                S_CAPTURE: begin
                    if (r_cap_cnt == CW'(CAPTURE_CYCLES - 1)) begin
                        r_pat_cnt   <= r_pat_cnt - PAT_CNT_WIDTH'(1);
                        r_shift_cnt <= '0;
                        r_se        <= 1'b1;
                        if (r_pat_cnt == PAT_CNT_WIDTH'(1)) begin
                            r_state <= S_UNLOAD;
                        end else begin
                            r_state <= S_SHIFT;
                            // PRPG held during capture, so the next load
                            // starts from its current value.
                            r_si    <= r_lfsr[NUM_CHAINS-1:0];
                        end
                    end else begin
                        r_cap_cnt <= r_cap_cnt + CW'(1);
                    end
                end

                S_UNLOAD: begin
                    r_misr <= w_misr_step;
                    if (r_shift_cnt == SW'(CHAIN_LEN - 1)) begin
                        r_state <= S_COMPARE;
                        r_se    <= 1'b0;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + SW'(1);
                    end
                end

                S_COMPARE: begin
                    r_pass      <= (r_misr == i_golden_sig);
                    r_done      <= 1'b1;
                    r_state     <= S_IDLE;
                    r_test_mode <= 1'b0;
                    r_busy      <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_si        = r_si;
    assign o_se        = r_se;
    assign o_test_mode = r_test_mode;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_signature = r_misr;

endmodule

// File: tb/tb_scan_lbist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_lbist_ctrl
// Bench for scan_lbist_ctrl with CHAIN_LEN=8, CAPTURE_CYCLES=1. Expected run
// results are queued when a run is launched and popped when it completes.
// -----------------------------------------------------------------------------
module tb_scan_lbist_ctrl;

    localparam int          L    = 8;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort_req;
    logic [15:0] num_pat;
    logic [15:0] golden;
    logic [3:0]  so;
    logic [3:0]  si;
    logic        se;
    logic        test_mode;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          busy_cycles;
        int          se_low;
        logic        pass;
        logic [15:0] sig;
    } exp_t;
    exp_t exp_q[$];

    // Scan-chain model: four L-deep shift registers clocked only while o_se=1.
    logic [L-1:0] chain [4];
    logic         use_chain;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (se) begin
            for (int k = 0; k < 4; k++) chain[k] <= {chain[k][L-2:0], si[k]};
        end
    end

    assign so = use_chain ? {chain[3][L-1], chain[2][L-1], chain[1][L-1], chain[0][L-1]} : 4'h0;

    scan_lbist_ctrl #(
        .CHAIN_LEN      (L),
        .CAPTURE_CYCLES (1)
    ) dut (
        .i_CLK          (clk),
        .i_RST          (rst_n),
        .i_start        (start),
        .i_abort        (abort_req),
        .i_num_patterns (num_pat),
        .i_golden_sig   (golden),
        .i_so           (so),
        .o_si           (si),
        .o_se           (se),
        .o_test_mode    (test_mode),
        .o_busy         (busy),
        .o_done         (done),
        .o_pass         (pass),
        .o_signature    (sig)
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0);
    endfunction

    function automatic logic [15:0] mstep(input logic [15:0] v, input logic [3:0] s);
        return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0) ^ {12'h0, s};
    endfunction

    // Reference signature for the chain model: each load is observed during the
    // following shift window (or the final unload); the first load's outputs are
    // not compacted.
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] l;
        logic [15:0] m;
        logic [3:0]  prev [L];
        logic [3:0]  cur  [L];
        l = SEED;
        m = 16'h0;
        for (int j = 0; j < L; j++) prev[j] = 4'h0;
        for (int p = 0; p < n; p++) begin
            for (int j = 0; j < L; j++) begin
                cur[j] = l[3:0];
                if (p > 0) m = mstep(m, prev[j]);
                l = lstep(l);
            end
            prev = cur;
        end
        for (int j = 0; j < L; j++) m = mstep(m, prev[j]);
        return m;
    endfunction

    function automatic exp_t make_exp(input int n, input logic p, input logic [15:0] s);
        exp_t e;
        e.busy_cycles = (n == 0) ? 2 : 1 + n * (L + 1) + L + 1;
        e.se_low      = n;
        e.pass        = p;
        e.sig         = s;
        return e;
    endfunction

    // Launches a run and observes it until o_busy drops. No checking here.
    task automatic run_collect(input logic [15:0] n, input logic [15:0] gold, input int pulse_at,
                               output int busy_cycles, output int se_low, output int se_high,
                               output bit tmo);
        int pend;
        bit seen;
        int guard;
        num_pat = n;
        golden  = gold;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_cycles = 0; se_low = 0; se_high = 0; tmo = 0;
        pend = 0; seen = 0; guard = 0;
        while (busy === 1'b1 && guard < 5000) begin
            busy_cycles++;
            start = (pulse_at >= 0 && busy_cycles == pulse_at);
            if (se === 1'b1) begin
                se_high++;
                seen   = 1;
                se_low += pend;
                pend   = 0;
            end else if (seen) begin
                pend++;
            end
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        if (guard >= 5000) tmo = 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort_req = 1'b0; num_pat = '0; golden = '0; use_chain = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if ({se, test_mode, done, pass} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {se, test_mode, done, pass}); end
        n_tests++; if (si !== 4'h0) begin n_fail++; $display("FAIL reset_si got=%h exp=0", si); end
        n_tests++; if (sig !== 16'h0000) begin n_fail++; $display("FAIL reset_sig got=%h exp=0000", sig); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int b, lo, hi; bit tmo; exp_t e;
        use_chain = 1'b0;
        exp_q.push_back(make_exp(3, 1'b1, 16'h0000));
        run_collect(16'd3, 16'h0000, -1, b, lo, hi, tmo);
        e = exp_q.pop_front();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL basic_timeout busy never dropped"); end
        n_tests++; if (b != e.busy_cycles) begin n_fail++; $display("FAIL basic_busy got=%0d exp=%0d", b, e.busy_cycles); end
        n_tests++; if (lo != e.se_low) begin n_fail++; $display("FAIL basic_se_low got=%0d exp=%0d", lo, e.se_low); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", done); end
        n_tests++; if (pass !== e.pass) begin n_fail++; $display("FAIL basic_pass got=%b exp=%b", pass, e.pass); end
        n_tests++; if (sig !== e.sig) begin n_fail++; $display("FAIL basic_sig got=%h exp=%h", sig, e.sig); end
    endtask

    task automatic test_signature;
        int b, lo, hi; bit tmo; exp_t e;
        logic [15:0] ref_sig;
        use_chain = 1'b1;
        ref_sig = model_sig(3);
        exp_q.push_back(make_exp(3, 1'b1, ref_sig));
        run_collect(16'd3, ref_sig, -1, b, lo, hi, tmo);
        e = exp_q.pop_front();
        n_tests++; if (tmo) begin n_fail++; $display("FAIL sig_timeout busy never dropped"); end
        n_tests++; if (sig !== e.sig) begin n_fail++; $display("FAIL sig_value got=%h exp=%h", sig, e.sig); end
        n_tests++; if (pass !== e.pass) begin n_fail++; $display("FAIL sig_pass got=%b exp=%b", pass, e.pass); end
        exp_q.push_back(make_exp(3, 1'b0, ref_sig));
        run_collect(16'd3, ref_sig ^ 16'h0001, -1, b, lo, hi, tmo);
        e = exp_q.pop_front();
        n_tests++; if (sig !== e.sig) begin n_fail++; $display("FAIL sig_rerun got=%h exp=%h", sig, e.sig); end
        n_tests++; if ({done, pass} !== {1'b1, e.pass}) begin n_fail++; $display("FAIL sig_badgold got=%b exp=%b", {done, pass}, {1'b1, e.pass}); end
        use_chain = 1'b0;
    endtask

    task automatic test_zero_patterns;
        int b, lo, hi; bit tmo; exp_t e;
        exp_q.push_back(make_exp(0, 1'b1, 16'h0000));
        run_collect(16'd0, 16'h0000, -1, b, lo, hi, tmo);
        e = exp_q.pop_front();
        n_tests++; if (b != e.busy_cycles) begin n_fail++; $display("FAIL zero_busy got=%0d exp=%0d", b, e.busy_cycles); end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL zero_se got=%0d exp=0", hi); end
        n_tests++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL zero_pass got=%b exp=11", {done, pass}); end
    endtask

    task automatic test_abort;
        int win, pos, guard, b, lo, hi; bit tmo; logic prev_se; exp_t e;
        num_pat = 16'd3; golden = 16'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        win = 0; pos = 0; guard = 0; prev_se = 1'b0;
        while (guard < 200) begin
            if (se === 1'b1 && prev_se !== 1'b1) begin win++; pos = 0; end
            if (se === 1'b1) pos++;
            prev_se = se;
            if (win == 2 && pos == 5) break;
            guard++;
            @(negedge clk);
        end
        n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL abort_reach never saw shift 5 of pattern 2"); end
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        n_tests++; if ({busy, se, test_mode, done} !== 4'b0) begin n_fail++; $display("FAIL abort_outputs got=%b exp=0000", {busy, se, test_mode, done}); end
        exp_q.push_back(make_exp(3, 1'b1, 16'h0000));
        run_collect(16'd3, 16'h0000, -1, b, lo, hi, tmo);
        e = exp_q.pop_front();
        n_tests++; if (b != e.busy_cycles) begin n_fail++; $display("FAIL abort_rerun_busy got=%0d exp=%0d", b, e.busy_cycles); end
        n_tests++; if ({done, pass} !== {1'b1, e.pass}) begin n_fail++; $display("FAIL abort_rerun_pass got=%b exp=11", {done, pass}); end
    endtask

    task automatic test_back_to_back;
        int b, lo, hi; bit tmo; exp_t e;
        exp_q.push_back(make_exp(3, 1'b1, 16'h0000));
        run_collect(16'd3, 16'h0000, 10, b, lo, hi, tmo);
        e = exp_q.pop_front();
        n_tests++; if (b != e.busy_cycles) begin n_fail++; $display("FAIL restart_ignored got=%0d exp=%0d", b, e.busy_cycles); end
        n_tests++; if (lo != e.se_low) begin n_fail++; $display("FAIL restart_se_low got=%0d exp=%0d", lo, e.se_low); end
    endtask

    task automatic test_reset_midrun;
        int guard; logic prev_se;
        num_pat = 16'd3; golden = 16'h0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0; prev_se = 1'b0;
        while (guard < 200 && !(prev_se === 1'b1 && se === 1'b0)) begin
            prev_se = se;
            guard++;
            @(negedge clk);
        end
        n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL rstmid_reach never reached capture"); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({busy, se, test_mode, done, pass, si} !== 9'b0) begin n_fail++; $display("FAIL rstmid_outputs got=%b exp=0", {busy, se, test_mode, done, pass, si}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (dut.r_lfsr !== SEED) begin n_fail++; $display("FAIL rstmid_lfsr got=%h exp=%h", dut.r_lfsr, SEED); end
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_si;
        int guard;
        logic [15:0] nxt;
        num_pat = 16'd1; golden = 16'h0;
        nxt = lstep(SEED);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (guard < 50 && se !== 1'b1) begin guard++; @(negedge clk); end
        n_tests++; if (guard >= 50) begin n_fail++; $display("FAIL si_reach o_se never rose"); end
        n_tests++; if (si !== 4'h1) begin n_fail++; $display("FAIL si_first got=%h exp=1", si); end
        @(negedge clk);
        n_tests++; if (si !== nxt[3:0]) begin n_fail++; $display("FAIL si_second got=%h exp=%h", si, nxt[3:0]); end
        guard = 0;
        while (guard < 200 && busy === 1'b1) begin guard++; @(negedge clk); end
        n_tests++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL si_run_end got=%b exp=11", {done, pass}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signature();
        test_zero_patterns();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_si();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
